// File: rtl/um_loader.sv
// um_loader: streams upstream elements into the unsorted memory (UM) of a
// sorter, zero-pads short frames, then hands the frame to the sorter with a
// one-cycle sort_start pulse and waits for sort_done before reloading.
// Optional build macro: UM_LOADER_MINMAX_EN adds min_val/max_val outputs
// tracking the extremes of the accepted (non-padding) elements of a frame.
`timescale 1ns/1ps

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ELEMENT_NUM
`define ELEMENT_NUM 16
`endif
`ifndef LOG2_ELEMENT_NUM
`define LOG2_ELEMENT_NUM 4
`endif

module um_loader (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [`DATA_WIDTH-1:0]         in_data,
    input  logic                           in_last,
    output logic                           in_ready,
    output logic                           um_wr_en,
    output logic [`LOG2_ELEMENT_NUM-1:0]   um_addr,
    output logic [`DATA_WIDTH-1:0]         um_wr_data,
    output logic                           sort_start,
    input  logic                           sort_done,
    output logic [`LOG2_ELEMENT_NUM:0]     elem_cnt
`ifdef UM_LOADER_MINMAX_EN
    ,
    output logic [`DATA_WIDTH-1:0]         min_val,
    output logic [`DATA_WIDTH-1:0]         max_val
`endif
);

    localparam int DW = `DATA_WIDTH;
    localparam int AW = `LOG2_ELEMENT_NUM;
    localparam logic [AW-1:0] LAST_ADDR = AW'(`ELEMENT_NUM - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW+1)'(`ELEMENT_NUM);

    // state   | meaning
    // S_LOAD  | accepting upstream elements, in_ready high
    // S_FILL  | short frame ended, writing zeros to the remaining addresses
    // S_START | last UM write is on the bus; raise sort_start next cycle
    // S_WAIT  | sorter owns the UM until sort_done
    typedef enum logic [1:0] {S_LOAD, S_FILL, S_START, S_WAIT} state_t;

    state_t          r_state,   w_state_nxt;
    logic [AW-1:0]   r_wr_ptr,  w_wr_ptr_nxt;
    logic            r_wr_en,   w_wr_en_nxt;
    logic [AW-1:0]   r_addr,    w_addr_nxt;
    logic [DW-1:0]   r_data,    w_data_nxt;
    logic            r_start,   w_start_nxt;
    logic [AW:0]     r_cnt,     w_cnt_nxt;

    // Next-state and next-output decode; UM outputs are all registered.
    always_comb begin
        w_state_nxt  = r_state;
        w_wr_ptr_nxt = r_wr_ptr;
        w_wr_en_nxt  = 1'b0;
        w_addr_nxt   = r_addr;
        w_data_nxt   = r_data;
        w_start_nxt  = 1'b0;
        w_cnt_nxt    = r_cnt;
        unique case (r_state)
            S_LOAD: begin
                if (in_valid) begin
                    w_wr_en_nxt  = 1'b1;
                    w_addr_nxt   = r_wr_ptr;
                    w_data_nxt   = in_data;
                    w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                    if (r_wr_ptr == LAST_ADDR) begin
                        w_cnt_nxt    = FULL_CNT;
                        w_wr_ptr_nxt = '0;
                        w_state_nxt  = S_START;
                    end else if (in_last) begin
                        w_cnt_nxt   = {1'b0, r_wr_ptr} + 1'b1;
                        w_state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                w_wr_en_nxt  = 1'b1;
                w_addr_nxt   = r_wr_ptr;
                w_data_nxt   = '0;
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
                if (r_wr_ptr == LAST_ADDR) begin
                    w_wr_ptr_nxt = '0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                w_start_nxt = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (sort_done) begin
                    w_wr_ptr_nxt = '0;
                    w_state_nxt  = S_LOAD;
                end
            end
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // State and registered output update; reset abandons any partial frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= '0;
            r_wr_en  <= 1'b0;
            r_addr   <= '0;
            r_data   <= '0;
            r_start  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_wr_ptr <= w_wr_ptr_nxt;
            r_wr_en  <= w_wr_en_nxt;
            r_addr   <= w_addr_nxt;
            r_data   <= w_data_nxt;
            r_start  <= w_start_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign in_ready   = (r_state == S_LOAD);
    assign um_wr_en   = r_wr_en;
    assign um_addr    = r_addr;
    assign um_wr_data = r_data;
    assign sort_start = r_start;
    assign elem_cnt   = r_cnt;

`ifdef UM_LOADER_MINMAX_EN
    logic [DW-1:0] r_min;
    logic [DW-1:0] r_max;

    // Track extremes of accepted elements; the first accept of a frame
    // (always at address 0) restarts them, so padding never contributes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_min <= '1;
            r_max <= '0;
        end else if (in_valid && (r_state == S_LOAD)) begin
            if ((r_wr_ptr == '0) || (in_data < r_min)) r_min <= in_data;
            if ((r_wr_ptr == '0) || (in_data > r_max)) r_max <= in_data;
        end
    end

    assign min_val = r_min;
    assign max_val = r_max;
`endif

endmodule

// File: tb/tb_um_loader.sv
`timescale 1ns/1ps

module tb_um_loader;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int NE = 16;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          in_valid   = 1'b0;
    logic [DW-1:0] in_data    = '0;
    logic          in_last    = 1'b0;
    logic          sort_done  = 1'b0;
    logic          in_ready;
    logic          um_wr_en;
    logic [AW-1:0] um_addr;
    logic [DW-1:0] um_wr_data;
    logic          sort_start;
    logic [AW:0]   elem_cnt;
`ifdef UM_LOADER_MINMAX_EN
    logic [DW-1:0] min_val;
    logic [DW-1:0] max_val;
`endif

    um_loader dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .um_wr_en   (um_wr_en),
        .um_addr    (um_addr),
        .um_wr_data (um_wr_data),
        .sort_start (sort_start),
        .sort_done  (sort_done),
        .elem_cnt   (elem_cnt)
`ifdef UM_LOADER_MINMAX_EN
        ,
        .min_val    (min_val),
        .max_val    (max_val)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Frame-level view: accepted elements produce a write in the next cycle;
    // closing a frame schedules the padding writes and the sort_start pulse
    // as a queue of future cycles; afterwards the loader waits for sort_done.
    typedef struct {
        bit wr;
        int addr;
        int data;
        bit start;
    } ev_t;

    ev_t q[$];
    ev_t ev;
    bit  m_ready = 1'b1;
    bit  m_wait  = 1'b0;
    int  m_ptr   = 0;
    int  m_cnt   = 0;
    int  m_min   = 255;
    int  m_max   = 0;
    bit  exp_wr    = 1'b0;
    bit  exp_start = 1'b0;
    int  exp_addr  = 0;
    int  exp_data  = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ready = 1'b1; m_wait = 1'b0; m_ptr = 0; m_cnt = 0;
            m_min = 255; m_max = 0;
            exp_wr = 1'b0; exp_start = 1'b0;
        end else begin
            exp_wr = 1'b0;
            exp_start = 1'b0;
            if (m_ready && in_valid) begin
                exp_wr = 1'b1; exp_addr = m_ptr; exp_data = int'(in_data);
                if (m_ptr == 0) begin
                    m_min = int'(in_data); m_max = int'(in_data);
                end else begin
                    if (int'(in_data) < m_min) m_min = int'(in_data);
                    if (int'(in_data) > m_max) m_max = int'(in_data);
                end
                if (m_ptr == NE - 1 || in_last) begin
                    m_cnt = m_ptr + 1;
                    for (int a = m_ptr + 1; a < NE; a++) q.push_back('{1'b1, a, 0, 1'b0});
                    q.push_back('{1'b0, 0, 0, 1'b1});
                    m_ready = 1'b0;
                    m_ptr = 0;
                end else begin
                    m_ptr++;
                end
            end else if (q.size() > 0) begin
                ev = q.pop_front();
                exp_wr = ev.wr; exp_addr = ev.addr; exp_data = ev.data; exp_start = ev.start;
                if (ev.start) m_wait = 1'b1;
            end else if (m_wait && sort_done) begin
                m_wait = 1'b0;
                m_ready = 1'b1;
            end
        end
    end

    // ---------------- compare process ----------------
    int n_wr    = 0;
    int n_zero  = 0;
    int n_start = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_in_ready", int'(in_ready), 1);
            chk("rst_wr_en", int'(um_wr_en), 0);
            chk("rst_addr", int'(um_addr), 0);
            chk("rst_data", int'(um_wr_data), 0);
            chk("rst_sort_start", int'(sort_start), 0);
            chk("rst_elem_cnt", int'(elem_cnt), 0);
`ifdef UM_LOADER_MINMAX_EN
            chk("rst_min_val", int'(min_val), 255);
            chk("rst_max_val", int'(max_val), 0);
`endif
        end else begin
            chk("in_ready", int'(in_ready), int'(m_ready));
            chk("um_wr_en", int'(um_wr_en), int'(exp_wr));
            if (exp_wr) begin
                chk("um_addr", int'(um_addr), exp_addr);
                chk("um_wr_data", int'(um_wr_data), exp_data);
            end
            chk("sort_start", int'(sort_start), int'(exp_start));
            chk("elem_cnt", int'(elem_cnt), m_cnt);
`ifdef UM_LOADER_MINMAX_EN
            if (exp_start) begin
                chk("min_val", int'(min_val), m_min);
                chk("max_val", int'(max_val), m_max);
            end
`endif
            if (um_wr_en) n_wr++;
            if (um_wr_en && um_wr_data == '0) n_zero++;
            if (sort_start) n_start++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic l);
        int guard;
        guard = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        while (!in_ready && guard < 200) begin
            step();
            guard++;
        end
        if (guard >= 200) chk("send_timeout", guard, 0);
        step();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!sort_start && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("sort_start_timeout", n, 0);
    endtask

    task automatic pulse_done();
        sort_done = 1'b1;
        step();
        sort_done = 1'b0;
    endtask

    int lat;
    int wr0, z0, s0;

    initial begin
        repeat (3) step();
        chk("reset_ready_lit", int'(in_ready), 1);
        chk("reset_cnt_lit", int'(elem_cnt), 0);
        rst = 1'b0;
        step();

        // full frame 15..0
        wr0 = n_wr;
        for (int i = 0; i < NE; i++) send(DW'(15 - i), 1'b0);
        wait_start(lat);
        chk("full_start_latency", lat, 1);
        chk("full_elem_cnt_lit", int'(elem_cnt), 16);
        chk("full_write_count", n_wr - wr0, 16);

        // backpressure in WAIT
        wr0 = n_wr;
        in_valid = 1'b1; in_data = 8'hAA;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_in_ready", int'(in_ready), 0);
        end
        chk("bp_no_writes", n_wr - wr0, 0);
        pulse_done();

        // short frame of 5, first element was held during backpressure
        wr0 = n_wr; z0 = n_zero;
        send(8'hAA, 1'b0);
        chk("bp_first_wr_en", int'(um_wr_en), 1);
        chk("bp_first_addr", int'(um_addr), 0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        wait_start(lat);
        chk("short_start_latency", lat, 12);
        chk("short_elem_cnt_lit", int'(elem_cnt), 5);
        chk("short_write_count", n_wr - wr0, 16);
        chk("short_fill_count", n_zero - z0, 11);
        pulse_done();

        // gaps, stray in_last and sort_done in LOAD, then reset at wr_ptr=7
        s0 = n_start; wr0 = n_wr;
        for (int k = 1; k <= 7; k++) begin
            send(DW'(k * 3), 1'b0);
            in_last = 1'b1; sort_done = 1'b1;
            step();
            in_last = 1'b0; sort_done = 1'b0;
        end
        chk("gap_in_ready", int'(in_ready), 1);
        chk("gap_no_start", n_start - s0, 0);
        chk("gap_write_count", n_wr - wr0, 7);
        chk("gap_elem_cnt_held", int'(elem_cnt), 5);
        rst = 1'b1;
        #1;
        chk("async_rst_wr_en", int'(um_wr_en), 0);
        chk("async_rst_cnt", int'(elem_cnt), 0);
        chk("async_rst_ready", int'(in_ready), 1);
        step();
        step();
        rst = 1'b0;
        step();

        // full frame with in_last on the 16th element, random data
        send(8'h5A, 1'b0);
        chk("post_rst_addr", int'(um_addr), 0);
        for (int i = 1; i < NE - 1; i++) send(DW'($urandom_range(1, 255)), 1'b0);
        send(8'h01, 1'b1);
        wait_start(lat);
        chk("last16_start_latency", lat, 1);
        chk("last16_elem_cnt_lit", int'(elem_cnt), 16);
        pulse_done();

        // min/max frame {9,3,200,3}
        send(8'd9, 1'b0);
        send(8'd3, 1'b0);
        send(8'd200, 1'b0);
        send(8'd3, 1'b1);
        wait_start(lat);
        chk("mm_start_latency", lat, 13);
        chk("mm_elem_cnt_lit", int'(elem_cnt), 4);
`ifdef UM_LOADER_MINMAX_EN
        chk("mm_min_lit", int'(min_val), 3);
        chk("mm_max_lit", int'(max_val), 200);
`endif
        pulse_done();
        repeat (4) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
